// File: rtl/gmii_arb_pkg.sv
// Shared types and constants for the GMII transmit arbiter.
// Holds the arbiter FSM encoding, GMII framing bytes and the inter-frame-gap floor.
package gmii_arb_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StGrant,
    StActive,
    StDrain,
    StIfg
  } arb_state_t;

  localparam logic [7:0]  GMII_PREAMBLE = 8'h55;
  localparam logic [7:0]  GMII_SFD      = 8'hD5;
  localparam int unsigned MIN_IFG       = 12;

  // Used at elaboration to reject gaps shorter than the 802.3 minimum.
  function automatic bit ifg_cycles_ok(input int unsigned ifg_cycles);
    return ifg_cycles >= MIN_IFG;
  endfunction

endpackage

// File: rtl/gmii_rr_picker.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
// Produces a one-hot selection and a valid flag.
module gmii_rr_picker #(
  parameter int unsigned NUM_SRC = 2,
  parameter int unsigned PTR_W   = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_SRC-1:0] sel,
  output logic               valid
);

  always_comb begin
    int unsigned j;
    logic [PTR_W-1:0] idx;
    sel   = '0;
    valid = 1'b0;
    j     = 0;
    idx   = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      j   = (32'(ptr) + i) % NUM_SRC;
      idx = PTR_W'(j);
      if (!valid && req[idx]) begin
        sel[idx] = 1'b1;
        valid    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/gmii_tx_arbiter.sv
// Round-robin arbiter sharing the GMII transmit path between frame sources.
// Enforces IFG, revokes stalled grants and truncates runaway or link-lost frames.
module gmii_tx_arbiter
  import gmii_arb_pkg::*;
#(
  parameter int unsigned NUM_SRC     = 2,
  parameter int unsigned IFG_CYCLES  = 12,
  parameter int unsigned GNT_TIMEOUT = 64,
  parameter int unsigned MAX_FRAME   = 1530
) (
  input  logic                 gmii_clk,
  input  logic                 sys_rst,
  input  logic                 link_up,
  input  logic [NUM_SRC-1:0]   src_req,
  output logic [NUM_SRC-1:0]   src_gnt,
  input  logic [NUM_SRC*8-1:0] src_tx_data,
  input  logic [NUM_SRC-1:0]   src_tx_en,
  input  logic [NUM_SRC-1:0]   src_tx_err,
  output logic [7:0]           gmii_tx_data,
  output logic                 gmii_tx_en,
  output logic                 gmii_tx_err,
  output logic                 busy,
  output logic [15:0]          timeout_cnt,
  output logic [15:0]          trunc_cnt
);

  localparam int unsigned IdxW  = $clog2(NUM_SRC);
  localparam int unsigned WaitW = $clog2(GNT_TIMEOUT);
  localparam int unsigned ByteW = $clog2(MAX_FRAME + 1);
  localparam int unsigned IfgW  = $clog2(IFG_CYCLES);

  localparam logic [WaitW-1:0] WaitLast = WaitW'(GNT_TIMEOUT - 1);
  localparam logic [ByteW-1:0] ByteMax  = ByteW'(MAX_FRAME);
  localparam logic [IfgW-1:0]  IfgLast  = IfgW'(IFG_CYCLES - 1);
  localparam logic [IdxW-1:0]  IdxLast  = IdxW'(NUM_SRC - 1);

  if (!ifg_cycles_ok(IFG_CYCLES)) begin : g_ifg_too_small
    $error("IFG_CYCLES must be at least MIN_IFG");
  end

  arb_state_t state_q, state_d;
  logic [NUM_SRC-1:0] gnt_q, gnt_d;
  logic [IdxW-1:0]    sel_q, sel_d;
  logic [IdxW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [WaitW-1:0]   wait_cnt_q, wait_cnt_d;
  logic [ByteW-1:0]   byte_cnt_q, byte_cnt_d;
  logic [IfgW-1:0]    ifg_cnt_q, ifg_cnt_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic               tx_en_q, tx_en_d;
  logic               tx_err_q, tx_err_d;
  logic               busy_q;
  logic [15:0]        timeout_cnt_q, trunc_cnt_q;
  logic               timeout_inc, trunc_inc;

  logic [NUM_SRC-1:0] pick_oh;
  logic               pick_valid;
  logic [IdxW-1:0]    pick_idx;

  logic [7:0] cur_data;
  logic       cur_en, cur_err, cur_req;

  gmii_rr_picker #(
    .NUM_SRC(NUM_SRC),
    .PTR_W  (IdxW)
  ) u_picker (
    .req  (src_req),
    .ptr  (rr_ptr_q),
    .sel  (pick_oh),
    .valid(pick_valid)
  );

  function automatic logic [IdxW-1:0] next_ptr(input logic [IdxW-1:0] idx);
    return (idx == IdxLast) ? '0 : idx + 1'b1;
  endfunction

  always_comb begin
    pick_idx = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (pick_oh[i]) pick_idx = IdxW'(i);
    end
  end

  // Only the selected source's lanes are ever looked at.
  assign cur_data = src_tx_data[{sel_q, 3'b000} +: 8];
  assign cur_en   = src_tx_en[sel_q];
  assign cur_err  = src_tx_err[sel_q];
  assign cur_req  = src_req[sel_q];

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    sel_d       = sel_q;
    rr_ptr_d    = rr_ptr_q;
    wait_cnt_d  = wait_cnt_q;
    byte_cnt_d  = byte_cnt_q;
    ifg_cnt_d   = ifg_cnt_q;
    tx_data_d   = '0;
    tx_en_d     = 1'b0;
    tx_err_d    = 1'b0;
    timeout_inc = 1'b0;
    trunc_inc   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (link_up && pick_valid) begin
          gnt_d      = pick_oh;
          sel_d      = pick_idx;
          wait_cnt_d = '0;
          state_d    = StGrant;
        end
      end
      StGrant: begin
        if (!link_up) begin
          gnt_d   = '0;
          state_d = StIdle;
        end else if (cur_en) begin
          tx_data_d  = cur_data;
          tx_en_d    = 1'b1;
          tx_err_d   = cur_err;
          byte_cnt_d = ByteW'(1);
          state_d    = StActive;
        end else if (!cur_req) begin
          gnt_d    = '0;
          rr_ptr_d = next_ptr(sel_q);
          state_d  = StIdle;
        end else if (wait_cnt_q == WaitLast) begin
          gnt_d       = '0;
          rr_ptr_d    = next_ptr(sel_q);
          timeout_inc = 1'b1;
          state_d     = StIdle;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      StActive: begin
        if (cur_en) begin
          tx_data_d  = cur_data;
          tx_en_d    = 1'b1;
          tx_err_d   = cur_err;
          byte_cnt_d = byte_cnt_q + 1'b1;
          // Last permitted byte or lost link: poison this byte and stop.
          if (byte_cnt_d == ByteMax || !link_up) begin
            tx_err_d  = 1'b1;
            gnt_d     = '0;
            trunc_inc = 1'b1;
            state_d   = StDrain;
          end
        end else begin
          gnt_d     = '0;
          rr_ptr_d  = next_ptr(sel_q);
          ifg_cnt_d = '0;
          state_d   = StIfg;
        end
      end
      StDrain: begin
        if (!cur_en) begin
          rr_ptr_d  = next_ptr(sel_q);
          ifg_cnt_d = '0;
          state_d   = StIfg;
        end
      end
      StIfg: begin
        if (ifg_cnt_q == IfgLast) begin
          state_d = StIdle;
        end else begin
          ifg_cnt_d = ifg_cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge gmii_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q       <= StIdle;
      gnt_q         <= '0;
      sel_q         <= '0;
      rr_ptr_q      <= '0;
      wait_cnt_q    <= '0;
      byte_cnt_q    <= '0;
      ifg_cnt_q     <= '0;
      tx_data_q     <= '0;
      tx_en_q       <= 1'b0;
      tx_err_q      <= 1'b0;
      busy_q        <= 1'b0;
      timeout_cnt_q <= '0;
      trunc_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      sel_q      <= sel_d;
      rr_ptr_q   <= rr_ptr_d;
      wait_cnt_q <= wait_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      ifg_cnt_q  <= ifg_cnt_d;
      tx_data_q  <= tx_data_d;
      tx_en_q    <= tx_en_d;
      tx_err_q   <= tx_err_d;
      busy_q     <= (state_d != StIdle);
      if (timeout_inc && timeout_cnt_q != 16'hFFFF) timeout_cnt_q <= timeout_cnt_q + 16'd1;
      if (trunc_inc && trunc_cnt_q != 16'hFFFF) trunc_cnt_q <= trunc_cnt_q + 16'd1;
    end
  end

  assign src_gnt      = gnt_q;
  assign gmii_tx_data = tx_data_q;
  assign gmii_tx_en   = tx_en_q;
  assign gmii_tx_err  = tx_err_q;
  assign busy         = busy_q;
  assign timeout_cnt  = timeout_cnt_q;
  assign trunc_cnt    = trunc_cnt_q;

endmodule

// File: tb/tb_gmii_tx_arbiter.sv
// Directed bench for gmii_tx_arbiter with two sources.
// Each step drives sources by hand and checks against hand-derived expectations.
module tb_gmii_tx_arbiter;
  import gmii_arb_pkg::*;

  logic        gmii_clk = 1'b0;
  logic        sys_rst;
  logic        link_up;
  logic [1:0]  src_req;
  logic [1:0]  src_gnt;
  logic [15:0] src_tx_data;
  logic [1:0]  src_tx_en;
  logic [1:0]  src_tx_err;
  logic [7:0]  gmii_tx_data;
  logic        gmii_tx_en;
  logic        gmii_tx_err;
  logic        busy;
  logic [15:0] timeout_cnt;
  logic [15:0] trunc_cnt;

  int checks = 0;
  int errors = 0;

  gmii_tx_arbiter #(
    .NUM_SRC    (2),
    .IFG_CYCLES (12),
    .GNT_TIMEOUT(64),
    .MAX_FRAME  (1530)
  ) dut (
    .gmii_clk    (gmii_clk),
    .sys_rst     (sys_rst),
    .link_up     (link_up),
    .src_req     (src_req),
    .src_gnt     (src_gnt),
    .src_tx_data (src_tx_data),
    .src_tx_en   (src_tx_en),
    .src_tx_err  (src_tx_err),
    .gmii_tx_data(gmii_tx_data),
    .gmii_tx_en  (gmii_tx_en),
    .gmii_tx_err (gmii_tx_err),
    .busy        (busy),
    .timeout_cnt (timeout_cnt),
    .trunc_cnt   (trunc_cnt)
  );

  always #4 gmii_clk = ~gmii_clk;

  initial begin
    #1ms;
    $display("FAIL watchdog expired observed=running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge gmii_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] fbyte(input int s, input int k);
    if (k < 7) return GMII_PREAMBLE;
    if (k == 7) return GMII_SFD;
    return 8'((k * 3 + s * 17) & 255);
  endfunction

  task automatic do_reset();
    sys_rst     = 1'b1;
    link_up     = 1'b1;
    src_req     = '0;
    src_tx_en   = '0;
    src_tx_err  = '0;
    src_tx_data = '0;
    repeat (3) tick();
    sys_rst = 1'b0;
    tick();
  endtask

  // Bounded wait for src_gnt[s]; also counts samples where gmii_tx_en was high.
  task automatic wait_gnt(input int s, input int limit, output int cyc, output int seen);
    cyc  = 0;
    seen = 0;
    while (src_gnt[s] !== 1'b1 && cyc < limit) begin
      tick();
      cyc++;
      if (gmii_tx_en !== 1'b0) seen++;
    end
  endtask

  // Source s sends n bytes starting the cycle after it sees its grant, then ends the frame.
  task automatic send_frame(input int s, input int n, output int bad);
    bad = 0;
    for (int k = 0; k < n; k++) begin
      src_tx_en[s]          = 1'b1;
      src_tx_data[8*s +: 8] = fbyte(s, k);
      tick();
      if (gmii_tx_en !== 1'b1 || gmii_tx_err !== 1'b0 || gmii_tx_data !== fbyte(s, k) ||
          src_gnt[s] !== 1'b1) bad++;
    end
    src_tx_en[s]          = 1'b0;
    src_req[s]            = 1'b0;
    src_tx_data[8*s +: 8] = '0;
    tick();
    if (gmii_tx_en !== 1'b0 || gmii_tx_data !== 8'h00 || src_gnt[s] !== 1'b0) bad++;
  endtask

  initial begin
    int cyc, seen, bad, bad2, bad3, cnt, s;

    // Reset values and a single 68-byte frame from src0.
    do_reset();
    check("rst_gnt", 32'(src_gnt), 0);
    check("rst_tx_en", 32'(gmii_tx_en), 0);
    check("rst_tx_data", 32'(gmii_tx_data), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_timeout_cnt", 32'(timeout_cnt), 0);
    check("rst_trunc_cnt", 32'(trunc_cnt), 0);

    src_req[0] = 1'b1;
    wait_gnt(0, 5, cyc, seen);
    check("t1_gnt_latency", cyc, 1);
    check("t1_gnt_onehot", 32'(src_gnt), 1);
    check("t1_busy", 32'(busy), 1);
    send_frame(0, 68, bad);
    check("t1_frame_bytes", bad, 0);
    // Frame-end sample is the first idle cycle: 12 IFG states minus that one, IDLE, then grant.
    src_req[0] = 1'b1;
    wait_gnt(0, 40, cyc, seen);
    check("t1_ifg_to_gnt", cyc, 13);
    check("t1_ifg_idle", seen, 0);
    send_frame(0, 4, bad);
    check("t1_frame2_bytes", bad, 0);

    // Two sources, two frames each: order 0,1,0,1.
    do_reset();
    src_req = 2'b11;
    for (int i = 0; i < 4; i++) begin
      s = i % 2;
      wait_gnt(s, 40, cyc, seen);
      check("t2_gnt_order", 32'(src_gnt), (s == 0) ? 32'd1 : 32'd2);
      check("t2_gap", cyc, (i == 0) ? 32'd1 : 32'd13);
      check("t2_gap_idle", seen, 0);
      send_frame(s, 20, bad);
      check("t2_frame_bytes", bad, 0);
      if (i < 2) src_req[s] = 1'b1;
    end

    // Grant timeout on src1 while src0 waits and wiggles its unselected lanes.
    do_reset();
    src_req[1] = 1'b1;
    wait_gnt(1, 5, cyc, seen);
    check("t3_gnt1", 32'(src_gnt), 2);
    src_req[0]          = 1'b1;
    src_tx_en[0]        = 1'b1;
    src_tx_err[0]       = 1'b1;
    src_tx_data[7:0]    = 8'hA5;
    cnt  = 0;
    seen = 0;
    while (src_gnt[1] === 1'b1 && cnt < 200) begin
      tick();
      cnt++;
      if (gmii_tx_en !== 1'b0 || gmii_tx_err !== 1'b0) seen++;
    end
    check("t3_revoke_cycles", cnt, 64);
    check("t3_unselected_ignored", seen, 0);
    check("t3_timeout_cnt", 32'(timeout_cnt), 1);
    check("t3_busy_idle", 32'(busy), 0);
    src_tx_en[0]     = 1'b0;
    src_tx_err[0]    = 1'b0;
    src_tx_data[7:0] = '0;
    src_req[1]       = 1'b0;
    wait_gnt(0, 5, cyc, seen);
    check("t3_next_gnt_src0", 32'(src_gnt), 1);
    check("t3_next_gnt_latency", cyc, 1);
    send_frame(0, 10, bad);
    check("t3_src0_frame", bad, 0);

    // Runaway frame from src0 is truncated at byte 1530.
    do_reset();
    src_req[0] = 1'b1;
    wait_gnt(0, 5, cyc, seen);
    bad  = 0;
    bad2 = 0;
    bad3 = 0;
    for (int k = 0; k < 2000; k++) begin
      src_tx_en[0]     = 1'b1;
      src_tx_data[7:0] = fbyte(0, k);
      if (k == 1600) src_req[1] = 1'b1;
      tick();
      if (k < 1529) begin
        if (gmii_tx_en !== 1'b1 || gmii_tx_err !== 1'b0 || gmii_tx_data !== fbyte(0, k)) bad++;
      end else if (k == 1529) begin
        check("t4_last_byte_en", 32'(gmii_tx_en), 1);
        check("t4_last_byte_err", 32'(gmii_tx_err), 1);
        check("t4_last_byte_data", 32'(gmii_tx_data), 32'(fbyte(0, k)));
        check("t4_gnt_dropped", 32'(src_gnt), 0);
        check("t4_trunc_cnt", 32'(trunc_cnt), 1);
      end else begin
        if (gmii_tx_en !== 1'b0 || gmii_tx_err !== 1'b0 || gmii_tx_data !== 8'h00) bad2++;
        if (src_gnt !== 2'b00) bad3++;
      end
    end
    check("t4_body_bytes", bad, 0);
    check("t4_drain_idle", bad2, 0);
    check("t4_drain_no_gnt", bad3, 0);
    src_tx_en[0]     = 1'b0;
    src_req[0]       = 1'b0;
    src_tx_data[7:0] = '0;
    // One cycle to leave DRAIN, 12 in IFG, one IDLE decision.
    wait_gnt(1, 40, cyc, seen);
    check("t4_gnt_after_drain_ifg", cyc, 14);
    check("t4_gnt_src1", 32'(src_gnt), 2);

    // Link loss at byte 30, then no grants until the link returns.
    do_reset();
    src_req[0] = 1'b1;
    wait_gnt(0, 5, cyc, seen);
    bad  = 0;
    bad2 = 0;
    for (int k = 0; k < 36; k++) begin
      src_tx_en[0]     = 1'b1;
      src_tx_data[7:0] = fbyte(0, k);
      if (k == 29) link_up = 1'b0;
      tick();
      if (k < 29) begin
        if (gmii_tx_en !== 1'b1 || gmii_tx_err !== 1'b0 || gmii_tx_data !== fbyte(0, k)) bad++;
      end else if (k == 29) begin
        check("t5_err_byte_en", 32'(gmii_tx_en), 1);
        check("t5_err_byte_err", 32'(gmii_tx_err), 1);
        check("t5_err_byte_data", 32'(gmii_tx_data), 32'(fbyte(0, k)));
      end else begin
        if (gmii_tx_en !== 1'b0 || gmii_tx_err !== 1'b0 || gmii_tx_data !== 8'h00) bad2++;
      end
    end
    check("t5_body_bytes", bad, 0);
    check("t5_after_err_idle", bad2, 0);
    check("t5_trunc_cnt", 32'(trunc_cnt), 1);
    src_tx_en[0]     = 1'b0;
    src_req[0]       = 1'b0;
    src_tx_data[7:0] = '0;
    src_req[1]       = 1'b1;
    bad3 = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (src_gnt !== 2'b00) bad3++;
    end
    check("t5_no_gnt_link_down", bad3, 0);
    check("t5_busy_link_down", 32'(busy), 0);
    link_up = 1'b1;
    wait_gnt(1, 2, cyc, seen);
    check("t5_relink_gnt", 32'(src_gnt), 2);
    check("t5_relink_latency_le2", 32'(cyc <= 2), 1);

    // Asynchronous reset mid-frame after the pointer has moved to src1.
    do_reset();
    src_req[0] = 1'b1;
    wait_gnt(0, 5, cyc, seen);
    send_frame(0, 10, bad);
    check("t6_src0_frame", bad, 0);
    src_req[1] = 1'b1;
    wait_gnt(1, 40, cyc, seen);
    check("t6_gnt_src1", 32'(src_gnt), 2);
    for (int k = 0; k < 10; k++) begin
      src_tx_en[1]      = 1'b1;
      src_tx_data[15:8] = fbyte(1, k);
      tick();
    end
    check("t6_mid_frame_en", 32'(gmii_tx_en), 1);
    src_req[0] = 1'b1;
    #2;
    sys_rst = 1'b1;
    #1;
    check("t6_async_tx_en", 32'(gmii_tx_en), 0);
    check("t6_async_gnt", 32'(src_gnt), 0);
    check("t6_async_busy", 32'(busy), 0);
    src_tx_en   = '0;
    src_tx_data = '0;
    src_req     = 2'b11;
    tick();
    tick();
    sys_rst = 1'b0;
    tick();
    check("t6_first_gnt_src0", 32'(src_gnt), 1);
    check("t6_tx_en_after_rst", 32'(gmii_tx_en), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
